// File: rtl/stream_acc_pkg.sv
// Shared fixed-point helpers for the stream accumulator: state encoding,
// saturation limits and a generic sign-extension helper.
package stream_acc_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Replicates bit w-1 of v into every bit above it.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational ACC_W signed adder with overflow flag.
// Define STREAM_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module fxp_sat_add
  import stream_acc_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W:0] w_full;

  assign w_full = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
  // Top two bits of the widened sum disagree exactly when same-signed operands flip sign.
  assign o_ovf  = w_full[ACC_W] ^ w_full[ACC_W-1];

`ifdef STREAM_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] MAXV = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MINV = ACC_W'(sat_min(ACC_W));

  // Bit ACC_W carries the true sign of the unbounded sum, so it picks the rail.
  assign o_sum = !o_ovf ? w_full[ACC_W-1:0] : (w_full[ACC_W] ? MINV : MAXV);
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/stream_frame_accumulator.sv
// Frame accumulator: sums FRAME_LEN signed samples from a valid/ready stream and
// holds the total on an output stream. Saturation via STREAM_ACC_SATURATE_EN.
module stream_frame_accumulator
  import stream_acc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, r_sum, w_ext, w_add;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid, r_ovf, r_ovf_trk;
  logic             w_add_ovf, w_accept, w_last, w_in_ready, w_clr;

  assign w_ext  = ACC_W'(sext(64'(data_in), DATA_W));
  assign w_last = (r_cnt == LAST_IDX);

  fxp_sat_add #(.ACC_W(ACC_W)) u_add (
    .i_a  (r_acc),
    .i_b  (w_ext),
    .o_sum(w_add),
    .o_ovf(w_add_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        w_clr      = clear;
        // clear wins over a sample offered in the same cycle
        w_accept   = in_valid && !clear;
        if (w_accept && w_last) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_out_valid && out_ready) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_ovf_trk   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_clr) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf_trk <= 1'b0;
      end else if (w_accept) begin
        if (w_last) begin
          r_sum       <= w_add;
          r_ovf       <= r_ovf_trk | w_add_ovf;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf_trk   <= 1'b0;
        end else begin
          r_acc     <= w_add;
          r_cnt     <= r_cnt + CNT_W'(1);
          r_ovf_trk <= r_ovf_trk | w_add_ovf;
        end
      end
      if (r_state == ST_HOLD && r_out_valid && out_ready) r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign sum_out    = r_sum;
  assign sample_cnt = r_cnt;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_stream_frame_accumulator.sv
// Self-checking bench: two instances (ACC_W=32 and ACC_W=18) share stimulus and
// are compared every cycle against an integer-arithmetic frame model.
module tb_stream_frame_accumulator;

`ifdef STREAM_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, out_ready;
  logic [15:0] data_in;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [31:0] sum_a;
  logic [4:0]  cnt_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [17:0] sum_b;
  logic [4:0]  cnt_b;

  bit rand_rdy = 1'b0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  stream_frame_accumulator u_dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .data_in(data_in), .out_valid(out_valid_a), .out_ready(out_ready), .sum_out(sum_a),
    .sample_cnt(cnt_a), .overflow(ovf_a)
  );

  stream_frame_accumulator #(.ACC_W(18)) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .data_in(data_in), .out_valid(out_valid_b), .out_ready(out_ready), .sum_out(sum_b),
    .sample_cnt(cnt_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference add on unbounded integers, then clamp or fold back into w bits.
  function automatic longint add_ref(input longint a, input longint x, input int w, output bit o);
    longint mx, mn, s;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    s  = a + x;
    o  = 1'b0;
    if (s > mx) begin
      o = 1'b1;
      s = SAT ? mx : s - (longint'(1) << w);
    end else if (s < mn) begin
      o = 1'b1;
      s = SAT ? mn : s + (longint'(1) << w);
    end
    return s;
  endfunction

  longint m_acc[2], m_sum[2];
  bit     m_fo[2], m_ov[2];
  int     m_cnt;
  bit     m_hold;
  int     m_w[2] = '{32, 18};

  always @(negedge clk) begin
    bit o;
    if (reset) begin
      m_hold = 1'b0;
      m_cnt  = 0;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_sum[k] = 0; m_fo[k] = 0; m_ov[k] = 0;
      end
    end else begin
      chk("in_ready_a", in_ready_a, !m_hold);
      chk("in_ready_b", in_ready_b, !m_hold);
      chk("out_valid_a", out_valid_a, m_hold);
      chk("out_valid_b", out_valid_b, m_hold);
      chk("cnt_a", cnt_a, m_cnt);
      chk("cnt_b", cnt_b, m_cnt);
      if (m_hold) begin
        chk("sum_a", longint'($signed(sum_a)), m_sum[0]);
        chk("sum_b", longint'($signed(sum_b)), m_sum[1]);
        chk("ovf_a", ovf_a, m_ov[0]);
        chk("ovf_b", ovf_b, m_ov[1]);
        if (out_ready) m_hold = 1'b0;
      end else if (clear) begin
        m_cnt = 0;
        for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_fo[k] = 0; end
      end else if (in_valid) begin
        for (int k = 0; k < 2; k++) begin
          m_acc[k] = add_ref(m_acc[k], longint'($signed(data_in)), m_w[k], o);
          m_fo[k]  = m_fo[k] | o;
        end
        m_cnt++;
        if (m_cnt == 16) begin
          for (int k = 0; k < 2; k++) begin
            m_sum[k] = m_acc[k]; m_ov[k] = m_fo[k]; m_acc[k] = 0; m_fo[k] = 0;
          end
          m_cnt  = 0;
          m_hold = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) if (rand_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  // All drive tasks start and end at posedge+1.
  task automatic send(input logic [15:0] x);
    bit acc = 1'b0;
    in_valid = 1'b1;
    data_in  = x;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = in_ready_a && !clear;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", in_ready_a, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_out(input string tag, input longint ea, input longint eb,
                          input bit eoa, input bit eob);
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid_a) begin seen = 1'b1; break; end
    end
    if (!seen) chk({tag, "_timeout"}, out_valid_a, 1);
    else begin
      chk({tag, "_sum_a"}, longint'(sum_a), ea);
      chk({tag, "_sum_b"}, longint'(sum_b), eb);
      chk({tag, "_ovf_a"}, ovf_a, eoa);
      chk({tag, "_ovf_b"}, ovf_b, eob);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {in_ready_a, in_ready_b}, 2'b11);
    chk({tag, "_out_valid"}, {out_valid_a, out_valid_b}, 2'b00);
    chk({tag, "_sum"}, longint'(sum_a) + longint'(sum_b), 0);
    chk({tag, "_cnt"}, {cnt_a, cnt_b}, 0);
    chk({tag, "_ovf"}, {ovf_a, ovf_b}, 2'b00);
  endtask

  task automatic reset_pulse(input string tag);
    #1 reset = 1'b1;
    #1 chk_reset_vals(tag);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por");
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 1; i <= 16; i++) send(16'(i));
    wait_out("ramp", 136, 136, 0, 0);

    for (int i = 0; i < 16; i++) send(16'hFFFF);
    wait_out("neg1", 32'hFFFF_FFF0, 18'h3FFF0, 0, 0);

    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(16'(i * 3));
    in_valid = 1'b1; data_in = 16'h0055;
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    send(16'h0055);
    for (int i = 0; i < 15; i++) send(16'd1);
    wait_out("held", 100, 100, 0, 0);

    for (int i = 0; i < 7; i++) send(16'd3);
    clear = 1'b1; in_valid = 1'b1; data_in = 16'd9;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 16; i++) send(16'd2);
    wait_out("clear", 32, 32, 0, 0);

    for (int i = 0; i < 16; i++) send(16'h7FFF);
    wait_out("maxpos", 32'h0007_FFF0, SAT ? 18'h1FFFF : 18'h3FFF0, 0, 1);

    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'd5);
    idle(2);
    reset_pulse("rst_hold");
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'd9);
    reset_pulse("rst_frame");
    for (int i = 1; i <= 16; i++) send(16'(i));
    wait_out("post_rst", 136, 136, 0, 0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 220; i++) begin
      int gap = $urandom_range(0, 2);
      if (gap != 0 && $urandom_range(0, 15) == 0) begin
        clear = 1'b1; in_valid = 1'($urandom_range(0, 1)); data_in = 16'($urandom);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
      end else idle(gap);
      case ($urandom_range(0, 5))
        0:       send(16'h7FFF);
        1:       send(16'h8000);
        default: send(16'($urandom));
      endcase
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_frame_accumulator.md
Name: stream_frame_accumulator

Overview:
- Parametrised successor to the free-running streaming accumulator.
- Sums fixed frames of FRAME_LEN two's-complement samples, arriving over a valid/ready input stream.
- Presents each frame total on a valid/ready output stream, then restarts from zero.
- Sits between sample producers (filters, ADC front-ends) and downstream averaging/normalisation in the fixed-point arithmetic unit.

Parameters:
- DATA_W, 16: input sample width, signed two's complement.
- ACC_W, 32: accumulator and sum_out width; must be >= DATA_W.
- FRAME_LEN, 16: samples per frame; range 1..65535.
- CNT_W, $clog2(FRAME_LEN+1): width of sample_cnt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort of the current frame.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block can accept a sample.
- data_in  in  DATA_W  signed sample.
- out_valid  out  1  sum_out holds a completed frame total.
- out_ready  in  1  downstream accepts sum_out.
- sum_out  out  ACC_W  signed frame total.
- sample_cnt  out  CNT_W  samples accepted in the current frame.
- overflow  out  1  the frame on sum_out saturated or wrapped.

Behaviour:
- Reset (async assert, sync release): state=ACCUM, acc=0, sample_cnt=0, sum_out=0, out_valid=0, overflow=0, in_ready=1.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1.
  - A sample is accepted when in_valid && in_ready at a clk edge.
  - On acceptance: acc <= acc + sext(data_in), sample_cnt++.
  - On acceptance of sample FRAME_LEN:
    - sum_out <= final sum; overflow <= frame overflow flag.
    - out_valid <= 1; acc <= 0; sample_cnt <= 0; state -> HOLD.
  - Latency: out_valid rises on the edge that accepts the last sample and is visible the following cycle.
- HOLD:
  - in_ready=0; sum_out and overflow stable.
  - out_valid && out_ready -> out_valid <= 0, state -> ACCUM. in_ready is 1 from the next cycle.
  - Throughput is therefore FRAME_LEN+1 cycles per frame with out_ready tied high.
- FRAME_LEN=1: every accepted sample goes straight to HOLD with sum = sext(data_in).
- Arithmetic:
  - data_in is sign-extended to ACC_W+1 bits, and the add is done at ACC_W+1 bits.
  - Per-add overflow = the two operands have equal signs and the result sign differs from them.
  - The frame overflow flag is the OR of per-add overflows across the frame, and is cleared at frame start.
- clear:
  - In ACCUM: acc <= 0, sample_cnt <= 0, overflow tracking reset. A sample presented the same cycle is dropped.
  - In HOLD: no effect; the pending result is preserved.
  - clear does not affect in_ready.
- in_valid held high while in_ready=0: no acceptance; the sample must be held by the source.
- Reset mid-frame or mid-HOLD: the partial sum and the pending output are discarded immediately.

Optional Feature:
- Macro STREAM_ACC_SATURATE_EN.
- Defined: on per-add overflow, acc clamps to the most positive (2^(ACC_W-1)-1) or most negative (-2^(ACC_W-1)) value. Subsequent adds continue from the clamped value and saturate again as needed. overflow is set.
- Undefined: acc wraps modulo 2^ACC_W. overflow still reports that a wrap occurred.

Decomposition:
- Shared package stream_acc_pkg holds:
  - the state encoding constants ST_ACCUM and ST_HOLD;
  - the sat_max(w) and sat_min(w) constant functions;
  - a sign-extension helper shared with the other fixed-point blocks.
- One natural sub-module, fxp_sat_add. It is a combinational ACC_W adder producing sum and ovf, with the saturating path selected by STREAM_ACC_SATURATE_EN. The FSM, counter and output registers stay in the top module.

Test Plan:
- Defaults, out_ready=1, inputs 1..16 on consecutive cycles -> one out_valid pulse, sum_out=136 (0x00000088), overflow=0, in_ready low exactly 1 cycle.
- Sixteen samples of 0xFFFF (-1) -> sum_out=0xFFFFFFF0, overflow=0.
- out_ready held low 5 cycles after frame completes -> out_valid and sum_out stable, in_ready=0, in_valid samples not accepted, no loss after release; next frame correct.
- clear asserted after 7 samples of value 3, then 16 samples of 2 -> sum_out=32; the 21 from the aborted samples is absent.
- ACC_W=18, sixteen samples of 0x7FFF:
  - with STREAM_ACC_SATURATE_EN -> sum_out=0x1FFFF, overflow=1;
  - without -> sum_out=0x3FFF0, overflow=1.
- Async reset pulse mid-HOLD and again mid-frame -> outputs return to reset values immediately; the next full frame of 1..16 gives 136.
